// File: rtl/enigma_stepper.sv
// Enigma front end: rotor position registers with odometer/double-step logic,
// keystroke handshake, and a registered output letter from the external core.
module enigma_stepper #(
  parameter int NOTCH1 = 16,
  parameter int NOTCH2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] init_r1,
  input  logic [4:0] init_r2,
  input  logic [4:0] init_r3,
  input  logic       key_valid,
  input  logic [4:0] key_in,
  output logic       key_ready,
  output logic [4:0] r1,
  output logic [4:0] r2,
  output logic [4:0] r3,
  output logic [4:0] enc_in,
  input  logic [4:0] enc_out,
  output logic       out_valid,
  output logic [4:0] out_letter,
  input  logic       out_ready,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, STEP, EVAL, DONE} state_t;

  localparam logic [4:0] N1 = 5'(NOTCH1);
  localparam logic [4:0] N2 = 5'(NOTCH2);

  state_t     state_q, state_d;
  logic [4:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [4:0] enc_in_q, enc_in_d, out_letter_q, out_letter_d;
  logic       out_valid_q, out_valid_d, err_q, err_d;
  logic       accept, key_ok;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  assign accept = key_valid && key_ready;
  assign key_ok = (key_in <= 5'd25);

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r1_q         <= 5'd0;
      r2_q         <= 5'd0;
      r3_q         <= 5'd0;
      enc_in_q     <= 5'd0;
      out_letter_q <= 5'd0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      r3_q         <= r3_d;
      enc_in_q     <= enc_in_d;
      out_letter_q <= out_letter_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && key_ok) state_d = STEP;
      STEP:    state_d = EVAL;
      EVAL:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r1_d         = r1_q;
    r2_d         = r2_q;
    r3_d         = r3_q;
    enc_in_d     = enc_in_q;
    out_letter_d = out_letter_q;
    out_valid_d  = out_valid_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          r1_d = clamp26(init_r1);
          r2_d = clamp26(init_r2);
          r3_d = clamp26(init_r3);
        end else if (accept) begin
          if (key_ok) enc_in_d = key_in;
          else        err_d    = 1'b1;
        end
      end
      STEP: begin
        // A middle rotor sitting on its own notch steps together with rotor 3.
        r1_d = inc26(r1_q);
        if (r1_q == N1 || r2_q == N2) r2_d = inc26(r2_q);
        if (r2_q == N2)               r3_d = inc26(r3_q);
      end
      EVAL: begin
        out_letter_d = enc_out;
        out_valid_d  = 1'b1;
      end
      DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    key_ready  = (state_q == IDLE) && !load;
    r1         = r1_q;
    r2         = r2_q;
    r3         = r3_q;
    enc_in     = enc_in_q;
    out_valid  = out_valid_q;
    out_letter = out_letter_q;
    err        = err_q;
  end

endmodule
